// File: rtl/unit_spawn_loader.sv
// Spawn loader: fetches unit stats/pixels from the ROMs, allocates the lowest free slot per side
// and emits one unit-table write. Define LOADER_QUEUE_EN to add a 4-entry request FIFO.
module unit_spawn_loader #(
  parameter int         SLOTS    = 8,
  parameter logic [9:0] ARMY_X0  = 10'd600,
  parameter logic [9:0] ENEMY_X0 = 10'd40,
  localparam int        SW       = $clog2(SLOTS),
  localparam int        CW       = SW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_side,
  input  logic [2:0]    req_type,
  output logic [2:0]    army_addr,
  output logic [1:0]    enemy_addr,
  input  logic [37:0]   army_stat,
  input  logic [37:0]   enemy_stat,
  input  logic [18:0]   army_pix,
  input  logic [18:0]   enemy_pix,
  input  logic          rel_valid,
  input  logic          rel_side,
  input  logic [SW-1:0] rel_slot,
  output logic          wr_en,
  output logic          wr_side,
  output logic [SW-1:0] wr_slot,
  output logic [2:0]    wr_type,
  output logic [11:0]   wr_hp,
  output logic [8:0]    wr_range,
  output logic [4:0]    wr_speed,
  output logic [4:0]    wr_cd,
  output logic [6:0]    wr_atk,
  output logic [6:0]    wr_w,
  output logic [6:0]    wr_h,
  output logic [4:0]    wr_d,
  output logic [9:0]    wr_x,
  output logic          rej,
  output logic [CW-1:0] army_cnt,
  output logic [CW-1:0] enemy_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, REJECT} state_t;

  state_t        state_q, state_d;
  logic          side_q, side_d;
  logic [2:0]    type_q, type_d;
  logic          wr_side_q, wr_side_d;
  logic [SW-1:0] wr_slot_q, wr_slot_d;
  logic [2:0]    wr_type_q, wr_type_d;
  logic [37:0]   stat_q, stat_d;
  logic [18:0]   pix_q, pix_d;
  logic [9:0]    x_q, x_d;
  logic [SLOTS-1:0] army_map_q, army_map_d, enemy_map_q, enemy_map_d;
  logic [CW-1:0] army_cnt_q, army_cnt_d, enemy_cnt_q, enemy_cnt_d;

  logic          start, in_side;
  logic [2:0]    in_type;
  logic [SLOTS-1:0] cur_map;
  logic          free_found, legal;
  logic [SW-1:0] free_slot;

`ifdef LOADER_QUEUE_EN
  logic [3:0] fifo_q [4];
  logic [3:0] fifo_d [4];
  logic [1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic       push, pop;

  always_comb begin
    push   = req_valid && (fcnt_q != 3'd4);
    pop    = (state_q == IDLE) && (fcnt_q != 3'd0);
    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      fifo_d[wptr_q] = {req_side, req_type};
      wptr_d         = wptr_q + 2'd1;
    end
    if (pop) rptr_d = rptr_q + 2'd1;
    fcnt_d = fcnt_q + 3'(push) - 3'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
    end else begin
      fifo_q <= fifo_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign req_ready = (fcnt_q != 3'd4);
  assign start     = pop;
  assign in_side   = fifo_q[rptr_q][3];
  assign in_type   = fifo_q[rptr_q][2:0];
`else
  assign req_ready = (state_q == IDLE);
  assign start     = req_valid && req_ready;
  assign in_side   = req_side;
  assign in_type   = req_type;
`endif

  // Allocation always looks at the pre-edge bitmap, so a same-cycle release is not seen.
  always_comb begin
    cur_map    = side_q ? enemy_map_q : army_map_q;
    free_found = 1'b0;
    free_slot  = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!cur_map[i]) begin
        free_found = 1'b1;
        free_slot  = SW'(i);
      end
    end
    legal = !(side_q && type_q[2]);
  end

  always_comb begin
    state_d   = state_q;
    side_d    = side_q;
    type_d    = type_q;
    wr_side_d = wr_side_q;
    wr_slot_d = wr_slot_q;
    wr_type_d = wr_type_q;
    stat_d    = stat_q;
    pix_d     = pix_q;
    x_d       = x_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          side_d  = in_side;
          type_d  = in_type;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (legal && free_found) begin
          state_d   = WRITE;
          wr_side_d = side_q;
          wr_slot_d = free_slot;
          wr_type_d = type_q;
          stat_d    = side_q ? enemy_stat : army_stat;
          pix_d     = side_q ? enemy_pix : army_pix;
          x_d       = side_q ? ENEMY_X0 : ARMY_X0;
        end else begin
          state_d = REJECT;
        end
      end
      WRITE:   state_d = IDLE;
      REJECT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Release first, then the write's set, so a slot written this edge always ends up occupied.
  always_comb begin
    army_map_d  = army_map_q;
    enemy_map_d = enemy_map_q;
    if (rel_valid) begin
      if (rel_side) enemy_map_d[rel_slot] = 1'b0;
      else          army_map_d[rel_slot]  = 1'b0;
    end
    if (state_q == WRITE) begin
      if (wr_side_q) enemy_map_d[wr_slot_q] = 1'b1;
      else           army_map_d[wr_slot_q]  = 1'b1;
    end
    army_cnt_d  = '0;
    enemy_cnt_d = '0;
    for (int i = 0; i < SLOTS; i++) begin
      army_cnt_d  = army_cnt_d + CW'(army_map_d[i]);
      enemy_cnt_d = enemy_cnt_d + CW'(enemy_map_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      side_q      <= 1'b0;
      type_q      <= '0;
      wr_side_q   <= 1'b0;
      wr_slot_q   <= '0;
      wr_type_q   <= '0;
      stat_q      <= '0;
      pix_q       <= '0;
      x_q         <= '0;
      army_map_q  <= '0;
      enemy_map_q <= '0;
      army_cnt_q  <= '0;
      enemy_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      side_q      <= side_d;
      type_q      <= type_d;
      wr_side_q   <= wr_side_d;
      wr_slot_q   <= wr_slot_d;
      wr_type_q   <= wr_type_d;
      stat_q      <= stat_d;
      pix_q       <= pix_d;
      x_q         <= x_d;
      army_map_q  <= army_map_d;
      enemy_map_q <= enemy_map_d;
      army_cnt_q  <= army_cnt_d;
      enemy_cnt_q <= enemy_cnt_d;
    end
  end

  assign army_addr  = (state_q == FETCH && !side_q) ? type_q : 3'd0;
  assign enemy_addr = (state_q == FETCH && side_q) ? type_q[1:0] : 2'd0;
  assign wr_en      = (state_q == WRITE);
  assign rej        = (state_q == REJECT);
  assign wr_side    = wr_side_q;
  assign wr_slot    = wr_slot_q;
  assign wr_type    = wr_type_q;
  assign wr_hp      = stat_q[37:26];
  assign wr_range   = stat_q[25:17];
  assign wr_speed   = stat_q[16:12];
  assign wr_cd      = stat_q[11:7];
  assign wr_atk     = stat_q[6:0];
  assign wr_w       = pix_q[18:12];
  assign wr_h       = pix_q[11:5];
  assign wr_d       = pix_q[4:0];
  assign wr_x       = x_q;
  assign army_cnt   = army_cnt_q;
  assign enemy_cnt  = enemy_cnt_q;

endmodule

// File: tb/tb_unit_spawn_loader.sv
// Randomized bench for unit_spawn_loader against a slot-occupancy reference model.
module tb_unit_spawn_loader;

  localparam int SLOTS = 8;
`ifdef LOADER_QUEUE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk, rst;
  logic        req_valid, req_ready, req_side;
  logic [2:0]  req_type, army_addr;
  logic [1:0]  enemy_addr;
  logic [37:0] army_stat, enemy_stat;
  logic [18:0] army_pix, enemy_pix;
  logic        rel_valid, rel_side;
  logic [2:0]  rel_slot;
  logic        wr_en, wr_side, rej;
  logic [2:0]  wr_slot, wr_type;
  logic [11:0] wr_hp;
  logic [8:0]  wr_range;
  logic [4:0]  wr_speed, wr_cd, wr_d;
  logic [6:0]  wr_atk, wr_w, wr_h;
  logic [9:0]  wr_x;
  logic [3:0]  army_cnt, enemy_cnt;

  logic [37:0] army_rom [8];
  logic [37:0] enemy_rom [4];
  logic [18:0] army_prom [8];
  logic [18:0] enemy_prom [4];

  bit          occ [2][SLOTS];
  logic [11:0] last_hp;
  int          last_slot;
  int          tests, failures;

  unit_spawn_loader dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_side(req_side), .req_type(req_type),
    .army_addr(army_addr), .enemy_addr(enemy_addr),
    .army_stat(army_stat), .enemy_stat(enemy_stat), .army_pix(army_pix), .enemy_pix(enemy_pix),
    .rel_valid(rel_valid), .rel_side(rel_side), .rel_slot(rel_slot),
    .wr_en(wr_en), .wr_side(wr_side), .wr_slot(wr_slot), .wr_type(wr_type),
    .wr_hp(wr_hp), .wr_range(wr_range), .wr_speed(wr_speed), .wr_cd(wr_cd), .wr_atk(wr_atk),
    .wr_w(wr_w), .wr_h(wr_h), .wr_d(wr_d), .wr_x(wr_x), .rej(rej),
    .army_cnt(army_cnt), .enemy_cnt(enemy_cnt)
  );

  assign army_stat  = army_rom[army_addr];
  assign enemy_stat = enemy_rom[enemy_addr];
  assign army_pix   = army_prom[army_addr];
  assign enemy_pix  = enemy_prom[enemy_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lowestFree(input int side);
    for (int i = 0; i < SLOTS; i++) if (!occ[side][i]) return i;
    return -1;
  endfunction

  function automatic int countOcc(input int side);
    int n = 0;
    for (int i = 0; i < SLOTS; i++) if (occ[side][i]) n++;
    return n;
  endfunction

  task automatic checkCounts();
    checkOutput("army_cnt", army_cnt, countOcc(0));
    checkOutput("enemy_cnt", enemy_cnt, countOcc(1));
  endtask

  // One request from acceptance to return to idle; optional release during the fetch cycle.
  task automatic applyStimulus(input bit side, input int typ, input bit doRel,
                               input bit relSide, input int relSlot);
    int          slot, guard;
    bit          ok;
    logic [37:0] st;
    logic [18:0] px;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("req_ready", req_ready, 1);
    slot = lowestFree(side);
    ok   = !(side && typ > 3) && (slot >= 0);
    st   = side ? enemy_rom[typ % 4] : army_rom[typ];
    px   = side ? enemy_prom[typ % 4] : army_prom[typ];
    req_valid = 1'b1;
    req_side  = side;
    req_type  = 3'(typ);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      checkOutput("early_strobe", {wr_en, rej}, 0);
      if (i == LAT - 1) begin
        checkOutput("army_addr", army_addr, side ? 0 : typ);
        checkOutput("enemy_addr", enemy_addr, side ? typ % 4 : 0);
        if (doRel) begin
          rel_valid = 1'b1;
          rel_side  = relSide;
          rel_slot  = 3'(relSlot);
        end
      end
      @(negedge clk);
      rel_valid = 1'b0;
    end
    if (doRel) occ[relSide][relSlot] = 1'b0;
    checkOutput("wr_en", wr_en, ok);
    checkOutput("rej", rej, !ok);
    if (ok) begin
      checkOutput("wr_side", wr_side, side);
      checkOutput("wr_slot", wr_slot, slot);
      checkOutput("wr_type", wr_type, typ);
      checkOutput("wr_hp", wr_hp, st[37:26]);
      checkOutput("wr_range", wr_range, st[25:17]);
      checkOutput("wr_speed", wr_speed, st[16:12]);
      checkOutput("wr_cd", wr_cd, st[11:7]);
      checkOutput("wr_atk", wr_atk, st[6:0]);
      checkOutput("wr_w", wr_w, px[18:12]);
      checkOutput("wr_h", wr_h, px[11:5]);
      checkOutput("wr_d", wr_d, px[4:0]);
      checkOutput("wr_x", wr_x, side ? 40 : 600);
      occ[side][slot] = 1'b1;
      last_hp   = st[37:26];
      last_slot = slot;
    end else begin
      checkOutput("hold_hp", wr_hp, last_hp);
      checkOutput("hold_slot", wr_slot, last_slot);
    end
    @(negedge clk);
    checkOutput("after_strobe", {wr_en, rej}, 0);
    checkCounts();
  endtask

  task automatic releaseSlot(input bit side, input int slot);
    rel_valid = 1'b1;
    rel_side  = side;
    rel_slot  = 3'(slot);
    @(negedge clk);
    rel_valid = 1'b0;
    occ[side][slot] = 1'b0;
    checkCounts();
  endtask

  task automatic resetDuringFetch();
    req_valid = 1'b1;
    req_side  = 1'b0;
    req_type  = 3'd1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 1; i < LAT - 1; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) for (int i = 0; i < SLOTS; i++) occ[s][i] = 1'b0;
    last_hp   = '0;
    last_slot = 0;
    checkOutput("rst_strobe", {wr_en, rej}, 0);
    checkOutput("rst_wr_hp", wr_hp, 0);
    checkCounts();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rst_no_strobe", {wr_en, rej}, 0);
    end
    checkOutput("rst_ready", req_ready, 1);
  endtask

`ifdef LOADER_QUEUE_EN
  task automatic fifoBurst();
    int pushed, writes, lastW;
    bit sawFull;
    pushed = 0; writes = 0; lastW = 0; sawFull = 0;
    for (int cyc = 0; cyc < 80 && writes < 8; cyc++) begin
      if (wr_en) begin
        checkOutput("burst_side", wr_side, 1);
        checkOutput("burst_slot", wr_slot, writes);
        checkOutput("burst_type", wr_type, writes % 4);
        if (writes > 0) checkOutput("burst_gap", cyc - lastW, 3);
        occ[1][writes] = 1'b1;
        last_hp = enemy_rom[writes % 4][37:26];
        lastW   = cyc;
        writes++;
      end
      if (pushed < 8) begin
        req_valid = 1'b1;
        req_side  = 1'b1;
        req_type  = 3'(pushed % 4);
        if (req_ready) pushed++;
        else           sawFull = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    checkOutput("burst_writes", writes, 8);
    checkOutput("burst_full_seen", sawFull, 1);
    @(negedge clk);
    checkCounts();
  endtask
`endif

  initial begin
    logic [63:0] r;
    tests = 0; failures = 0;
    last_hp = '0; last_slot = 0;
    for (int i = 0; i < 8; i++) begin
      r = {$urandom(), $urandom()};
      army_rom[i]  = r[37:0];
      army_prom[i] = r[56:38];
    end
    for (int i = 0; i < 4; i++) begin
      r = {$urandom(), $urandom()};
      enemy_rom[i]  = r[37:0];
      enemy_prom[i] = r[56:38];
    end
    army_rom[2][37:26] = 12'd1500;
    army_rom[2][6:0]   = 7'd1;
    enemy_rom[0][37:26] = 12'd500;

    rst = 1'b1; req_valid = 1'b0; req_side = 1'b0; req_type = '0;
    rel_valid = 1'b0; rel_side = 1'b0; rel_slot = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_strobe", {wr_en, rej}, 0);
    checkOutput("reset_hp", wr_hp, 0);
    checkOutput("reset_x", wr_x, 0);
    checkOutput("reset_addr", {army_addr, enemy_addr}, 0);
    checkCounts();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", req_ready, 1);

    applyStimulus(0, 2, 0, 0, 0);
    for (int i = 0; i < SLOTS; i++) applyStimulus(0, int'($urandom_range(0, 7)), 0, 0, 0);
    releaseSlot(0, 3);
    applyStimulus(0, 4, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 5);
    applyStimulus(0, 6, 0, 0, 0);
    applyStimulus(1, 5, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0)
        releaseSlot(1'($urandom_range(0, 1)), int'($urandom_range(0, SLOTS - 1)));
      else
        applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                      $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, SLOTS - 1)));
    end

    resetDuringFetch();
    applyStimulus(1, 3, 0, 0, 0);
`ifdef LOADER_QUEUE_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) for (int i = 0; i < SLOTS; i++) occ[s][i] = 1'b0;
    @(negedge clk);
    fifoBurst();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
